fadd_sched: RTL and testbench

FADD_SCHED -- requirements
Module: fadd_sched

---
 rtl/fadd_sched.sv | 146 ++++++++++++++
 tb/tb_fadd_sched.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_sched.sv
// Two-requester round-robin scheduler for a shared fixed-latency FP adder.
// Credit-gated per-requester result FIFOs; sticky error on tag/return misalignment.
module fadd_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,
    output logic        res0_valid,
    input  logic        res0_ready,
    output logic [31:0] res0_data,
    output logic        res1_valid,
    input  logic        res1_ready,
    output logic [31:0] res1_data,
    output logic [31:0] fa_a,
    output logic [31:0] fa_b,
    output logic        fa_en,
    input  logic [31:0] fa_c,
    input  logic        fa_ready,
    output logic        err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = $clog2(LAT + 1);
    localparam logic [CW:0]   LIMIT     = DEPTH[CW:0];
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [SW-1:0] SUPP_INIT = SW'(LAT);

    logic [CW-1:0]  inflight [2];
    logic [CW-1:0]  count    [2];
    logic [CW:0]    occ      [2];
    logic [PW-1:0]  wr_ptr   [2];
    logic [PW-1:0]  rd_ptr   [2];
    logic [31:0]    mem      [2][DEPTH];
    logic [LAT-1:0] tag_v;
    logic [LAT-1:0] tag_id;
    logic           tag_out_v;
    logic           tag_out_id;
    logic           last;
    logic [SW-1:0]  supp;
    logic [1:0]     valid;
    logic [1:0]     elig;
    logic [1:0]     grant;
    logic [1:0]     push;
    logic [1:0]     pop;
    logic [1:0]     res_rdy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    assign valid   = {req1_valid, req0_valid};
    assign res_rdy = {res1_ready, res0_ready};

    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            occ[n]  = {1'b0, inflight[n]} + {1'b0, count[n]};
            elig[n] = valid[n] && (occ[n] < LIMIT) && !rst;
        end
        // last=1 means requester 1 won most recently, so requester 0 has priority
        grant[0] = elig[0] && (!elig[1] || last);
        grant[1] = elig[1] && (!elig[0] || !last);
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign fa_en      = |grant;

    always_comb begin
        fa_a = '0;
        fa_b = '0;
        if (grant[0]) begin
            fa_a = req0_a;
            fa_b = {req0_b[31] ^ req0_sub, req0_b[30:0]};
        end else if (grant[1]) begin
            fa_a = req1_a;
            fa_b = {req1_b[31] ^ req1_sub, req1_b[30:0]};
        end
    end

    assign tag_out_v  = tag_v[LAT-1];
    assign tag_out_id = tag_id[LAT-1];
    assign push       = {tag_out_v & tag_out_id, tag_out_v & ~tag_out_id};

    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            pop[n] = res_rdy[n] && (count[n] != '0);
        end
    end

    assign res0_valid = !rst && (count[0] != '0);
    assign res1_valid = !rst && (count[1] != '0);
    assign res0_data  = mem[0][rd_ptr[0]];
    assign res1_data  = mem[1][rd_ptr[1]];

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_v  <= '0;
            tag_id <= '0;
            last   <= 1'b1;
            supp   <= SUPP_INIT;
            err    <= 1'b0;
            for (int unsigned n = 0; n < 2; n++) begin
                inflight[n] <= '0;
                count[n]    <= '0;
                wr_ptr[n]   <= '0;
                rd_ptr[n]   <= '0;
            end
        end else begin
            for (int unsigned i = LAT - 1; i > 0; i--) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            tag_v[0]  <= fa_en;
            tag_id[0] <= grant[1];
            if (fa_en) last <= grant[1];
            // adder pipe is not reset, so stale returns may appear for LAT cycles
            if (supp != '0) supp <= supp - SW'(1);
            else if (fa_ready != tag_out_v) err <= 1'b1;
            for (int unsigned n = 0; n < 2; n++) begin
                inflight[n] <= inflight[n] + CW'(grant[n]) - CW'(push[n]);
                count[n]    <= count[n] + CW'(push[n]) - CW'(pop[n]);
                if (push[n]) wr_ptr[n] <= ptr_inc(wr_ptr[n]);
                if (pop[n])  rd_ptr[n] <= ptr_inc(rd_ptr[n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < 2; n++) begin
            if (push[n]) mem[n][wr_ptr[n]] <= fa_c;
        end
    end

endmodule

// File: tb/tb_fadd_sched.sv
// Self-checking bench for fadd_sched: behavioural adder pipe plus per-requester
// result scoreboards, with directed scenario tasks.
module tb_fadd_sched;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        res0_valid, res0_ready;
    logic [31:0] res0_data;
    logic        res1_valid, res1_ready;
    logic [31:0] res1_data;
    logic [31:0] fa_a, fa_b, fa_c;
    logic        fa_en, fa_ready, err;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic [31:0] mon_e;

    logic [31:0]    pipe_d [LAT];
    logic [LAT-1:0] pipe_v = '0;
    logic           force_rdy = 1'b0;

    fadd_sched #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
        .res0_valid(res0_valid), .res0_ready(res0_ready), .res0_data(res0_data),
        .res1_valid(res1_valid), .res1_ready(res1_ready), .res1_data(res1_data),
        .fa_a(fa_a), .fa_b(fa_b), .fa_en(fa_en), .fa_c(fa_c), .fa_ready(fa_ready), .err(err)
    );

    always #5 clk = ~clk;

    function automatic real sp_to_real(input logic [31:0] x);
        logic [10:0] e;
        if (x[30:0] == 31'd0) return 0.0;
        e = {3'b000, x[30:23]} + 11'd896;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int_to_sp(input int k);
        return real_to_sp(real'(k));
    endfunction

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        real ra, rb;
        ra = sp_to_real(a);
        rb = sp_to_real(b);
        if (sub) rb = -rb;
        return real_to_sp(ra + rb);
    endfunction

    // behavioural adder: no reset, fixed LAT-cycle latency
    always @(posedge clk) begin
        pipe_v[0] <= fa_en;
        pipe_d[0] <= real_to_sp(sp_to_real(fa_a) + sp_to_real(fa_b));
        for (int i = 1; i < LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_d[i] <= pipe_d[i-1];
        end
    end
    assign fa_ready = pipe_v[LAT-1] | force_rdy;
    assign fa_c     = pipe_d[LAT-1];

    // scoreboard: expected pushed on acceptance, popped on delivery
    always @(negedge clk) begin
        if (req0_ready) exp0.push_back(ref_add(req0_a, req0_b, req0_sub));
        if (req1_ready) exp1.push_back(ref_add(req1_a, req1_b, req1_sub));
        if (res0_valid && res0_ready) begin
            checks++;
            if (exp0.size() == 0) begin
                errors++;
                $display("FAIL res0_data: got %h, required no result", res0_data);
            end else begin
                mon_e = exp0.pop_front();
                if (res0_data !== mon_e) begin
                    errors++;
                    $display("FAIL res0_data: got %h, required %h", res0_data, mon_e);
                end
            end
        end
        if (res1_valid && res1_ready) begin
            checks++;
            if (exp1.size() == 0) begin
                errors++;
                $display("FAIL res1_data: got %h, required no result", res1_data);
            end else begin
                mon_e = exp1.pop_front();
                if (res1_data !== mon_e) begin
                    errors++;
                    $display("FAIL res1_data: got %h, required %h", res1_data, mon_e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        req0_valid = v; req0_a = a; req0_b = b; req0_sub = s;
    endtask

    task automatic drive1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
        req1_valid = v; req1_a = a; req1_b = b; req1_sub = s;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        exp0.delete();
        exp1.delete();
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (exp0.size() == 0 && exp1.size() == 0 && !res0_valid && !res1_valid) ok = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive0(1'b1, int_to_sp(1), int_to_sp(2), 1'b0);
        drive1(1'b1, int_to_sp(3), int_to_sp(4), 1'b1);
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b, required 00", {req1_ready, req0_ready});
        end
        checks++;
        if ({res1_valid, res0_valid} !== 2'b00) begin
            errors++; $display("FAIL reset_res_valid: got %b, required 00", {res1_valid, res0_valid});
        end
        checks++;
        if (fa_en !== 1'b0) begin errors++; $display("FAIL reset_fa_en: got %b, required 0", fa_en); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err); end
        tick();
        rst = 1'b0;
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        checks++;
        if ({fa_en, fa_a, fa_b} !== 65'd0) begin
            errors++; $display("FAIL idle_fa: got en=%b a=%h b=%h, required all 0", fa_en, fa_a, fa_b);
        end
        tick();
    endtask

    task automatic test_single();
        drive0(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        @(negedge clk);
        checks++;
        if ({fa_en, req0_ready} !== 2'b11) begin
            errors++; $display("FAIL single_issue: got en=%b rdy=%b, required 1 1", fa_en, req0_ready);
        end
        checks++;
        if (fa_a !== 32'h3F800000 || fa_b !== 32'h40000000) begin
            errors++; $display("FAIL single_operands: got %h %h, required 3f800000 40000000", fa_a, fa_b);
        end
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (res0_valid !== 1'b0) begin
                errors++; $display("FAIL single_early: cycle %0d got res0_valid=%b, required 0", c, res0_valid);
            end
            if (c == 1) begin
                checks++;
                if ({fa_en, fa_a, fa_b} !== 65'd0) begin
                    errors++; $display("FAIL single_idle_fa: got en=%b a=%h b=%h, required all 0", fa_en, fa_a, fa_b);
                end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (res0_valid !== 1'b1 || res0_data !== 32'h40400000) begin
            errors++; $display("FAIL single_result: got v=%b d=%h, required 1 40400000", res0_valid, res0_data);
        end
        tick();
    endtask

    task automatic test_sub();
        bit got;
        logic [31:0] d;
        got = 1'b0;
        d = '0;
        drive1(1'b1, 32'h40400000, 32'h3F800000, 1'b1);
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || fa_a !== 32'h40400000 || fa_b !== 32'hBF800000) begin
            errors++; $display("FAIL sub_issue: got rdy=%b a=%h b=%h, required 1 40400000 bf800000", req1_ready, fa_a, fa_b);
        end
        tick();
        drive1(1'b0, 32'd0, 32'd0, 1'b0);
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (res1_valid) begin
                got = 1'b1;
                d = res1_data;
            end
            tick();
        end
        checks++;
        if (!got || d !== 32'h40000000) begin
            errors++; $display("FAIL sub_result: got seen=%b d=%h, required 1 40000000", got, d);
        end
    endtask

    task automatic test_back_to_back();
        int k0, k1, turn;
        bit ok;
        do_reset(1);
        res0_ready = 1'b1;
        res1_ready = 1'b1;
        k0 = 0; k1 = 0; turn = 0;
        for (int c = 0; c < 16; c++) begin
            drive0(1'b1, int_to_sp(k0 + 1), int_to_sp(2 * k0 + 3), 1'(k0 % 2));
            drive1(1'b1, int_to_sp(20 + k1), int_to_sp(k1 + 5), 1'((k1 + 1) % 2));
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready} !== ((turn == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL b2b_grant: cycle %0d got %b, required turn %0d", c, {req1_ready, req0_ready}, turn);
            end
            checks++;
            if (fa_en !== 1'b1) begin errors++; $display("FAIL b2b_fa_en: cycle %0d got %b, required 1", c, fa_en); end
            if (req0_ready) k0++;
            if (req1_ready) k1++;
            turn = 1 - turn;
            tick();
        end
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 1'b0);
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_drain: got pending %0d/%0d, required 0/0", exp0.size(), exp1.size()); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: got %b, required 0", err); end
    endtask

    task automatic test_credit();
        int rel0[$];
        int g1_pre, g1_post, pops1, last, k0, k1;
        bit e0, e1, eg0, eg1, ok;
        do_reset(1);
        res0_ready = 1'b1;
        res1_ready = 1'b0;
        g1_pre = 0; g1_post = 0; pops1 = 0; last = 1; k0 = 0; k1 = 0;
        for (int t = 0; t < 32; t++) begin
            while (rel0.size() > 0 && rel0[0] < t) void'(rel0.pop_front());
            e0  = rel0.size() < DEPTH;
            e1  = (g1_pre + g1_post - pops1) < DEPTH;
            eg0 = e0 && (!e1 || last == 1);
            eg1 = e1 && (!e0 || last == 0);
            drive0(1'b1, int_to_sp(k0 + 2), int_to_sp(k0 + 1), 1'(k0 % 2));
            drive1(1'b1, int_to_sp(k1 + 7), int_to_sp(3), 1'b0);
            res1_ready = (t == 20);
            @(negedge clk);
            checks++;
            if ({req1_ready, req0_ready} !== {eg1, eg0}) begin
                errors++; $display("FAIL credit_grant: cycle %0d got %b, required %b", t, {req1_ready, req0_ready}, {eg1, eg0});
            end
            if (t == 20) begin
                checks++;
                if (res1_valid !== 1'b1) begin errors++; $display("FAIL credit_full: got res1_valid=%b, required 1", res1_valid); end
                pops1++;
            end
            if (eg0) begin rel0.push_back(t + LAT + 1); last = 0; end
            if (eg1) last = 1;
            if (req1_ready) begin
                if (t < 20) g1_pre++;
                else g1_post++;
                k1++;
            end
            if (req0_ready) k0++;
            tick();
        end
        checks++;
        if (g1_pre != 4) begin errors++; $display("FAIL credit_req1_limit: got %0d grants, required 4", g1_pre); end
        checks++;
        if (g1_post != 1) begin errors++; $display("FAIL credit_req1_regain: got %0d grants, required 1", g1_post); end
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        drive1(1'b0, 32'd0, 32'd0, 1'b0);
        res1_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL credit_drain: got pending %0d/%0d, required 0/0", exp0.size(), exp1.size()); end
    endtask

    task automatic test_reset_flush();
        bit got;
        bit ok;
        do_reset(1);
        drive0(1'b1, int_to_sp(5), int_to_sp(6), 1'b0);
        tick();
        drive0(1'b1, int_to_sp(7), int_to_sp(8), 1'b0);
        tick();
        drive0(1'b0, 32'd0, 32'd0, 1'b0);
        do_reset(1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if ({res1_valid, res0_valid, err} !== 3'b000) begin
                errors++; $display("FAIL flush_stale: cycle %0d got v=%b err=%b, required 00 0", c, {res1_valid, res0_valid}, err);
            end
            tick();
        end
        drive1(1'b1, int_to_sp(9), int_to_sp(4), 1'b1);
        tick();
        drive1(1'b0, 32'd0, 32'd0, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (res1_valid) got = 1'b1;
            tick();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL flush_new_traffic: got no res1_valid, required 1"); end
        wait_drain(ok);
        checks++;
        if (!ok || err !== 1'b0) begin errors++; $display("FAIL flush_end: got drained=%b err=%b, required 1 0", ok, err); end
    endtask

    task automatic test_err();
        do_reset(1);
        for (int c = 0; c < 11; c++) begin
            force_rdy = (c == 10);
            @(negedge clk);
            checks++;
            if (err !== 1'b0) begin errors++; $display("FAIL err_early: cycle %0d got %b, required 0", c, err); end
            tick();
        end
        force_rdy = 1'b0;
        for (int c = 11; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: cycle %0d got %b, required 1", c, err); end
            tick();
        end
        do_reset(1);
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || res0_valid !== 1'b0) begin
            errors++; $display("FAIL err_clear: got err=%b res0_valid=%b, required 0 0", err, res0_valid);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, required finish before timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_sub();
        test_back_to_back();
        test_credit();
        test_reset_flush();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
